dmem_responder: RTL and testbench

// - Data-memory responder: the memory-side end of the CPU data bus (memWrite/dataAdr/writeData).
// - Serves word reads and byte-enabled writes from a word RAM after WAIT_CYCLES programmable wait states.
// - Signals completion with a one-cycle memReady handshake.
// - Decodes one status word at TOHOST_ADR; a write there reports end-of-test pass/fail to the bench and is not stored.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_bank.sv | 25 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// word-address offset and the address range check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADR_LSB = 2;

  // True when a byte address falls inside a RAM of depth 32-bit words.
  function automatic logic in_range(input logic [31:0] adr, input int unsigned depth);
    logic [33:0] lim;
    lim = 34'(depth) << 2;
    return ({2'b00, adr} < lim);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-bus bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;

  // Handshake: the master raises memRead and/or memWrite with dataAdr, writeData
  // and byteEn, and holds them stable until it sees memReady=1. memReady is a
  // one-cycle pulse; readData is valid while it is high for a read.
  logic        memRead;
  logic        memWrite;
  logic [31:0] dataAdr;
  logic [31:0] writeData;
  logic [3:0]  byteEn;
  logic [31:0] readData;
  logic        memReady;

  modport master (
    output memRead, memWrite, dataAdr, writeData, byteEn,
    input  readData, memReady
  );

  modport slave (
    input  memRead, memWrite, dataAdr, writeData, byteEn,
    output readData, memReady
  );

endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 synchronous word RAM with per-byte write enables and a
// registered read port that holds its value while re is low.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU data bus: word reads, byte-enabled writes after
// WAIT_CYCLES wait states, plus a tohost status word for end-of-test reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADR  = 32'h54,
  parameter logic [31:0] PASS_VALUE  = 32'd7
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic             simDone,
  output logic             simPass,
  output logic             adrErr,
  output state_t           dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   adr_q, wdata_q, rd_hold_q;
  logic [3:0]    be_q;
  logic          wr_q;

  logic          req, resp;
  logic [31:0]   cur_adr;
  logic          cur_wr, cur_ok;
  logic          q_tohost, q_ok;
  logic [3:0]    bank_we;
  logic          bank_re;
  logic [31:0]   bank_rdata, live_rd;

  assign req  = bus.memRead | bus.memWrite;
  assign resp = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(WAIT_CYCLES - 1)) state_d = RESP;
        else cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM read is launched in the cycle before RESP; with no wait states
  // that cycle is IDLE, so the live bus address is used before it is latched.
  assign cur_adr = (state_q == IDLE) ? bus.dataAdr : adr_q;
  assign cur_wr  = (state_q == IDLE) ? bus.memWrite : wr_q;
  assign cur_ok  = in_range(cur_adr, DEPTH) && (cur_adr[31:2] != TOHOST_ADR[31:2]);
  assign bank_re = (state_d == RESP) && !cur_wr && cur_ok;

  assign q_tohost = (adr_q[31:2] == TOHOST_ADR[31:2]);
  assign q_ok     = in_range(adr_q, DEPTH) && !q_tohost;
  assign bank_we  = (resp && wr_q && q_ok && rst) ? be_q : 4'b0000;

  dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (adr_q[ADR_LSB +: AW]),
    .wdata (wdata_q),
    .re    (bank_re),
    .raddr (cur_adr[ADR_LSB +: AW]),
    .rdata (bank_rdata)
  );

  always_comb begin
    live_rd = 32'h0;
    if (q_tohost)  live_rd = {30'b0, simPass, simDone};
    else if (q_ok) live_rd = bank_rdata;
  end

  assign bus.readData = (resp && !wr_q) ? live_rd : rd_hold_q;
  assign bus.memReady = resp;
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      wr_q      <= 1'b0;
      rd_hold_q <= 32'h0;
      simDone   <= 1'b0;
      simPass   <= 1'b0;
      adrErr    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        adr_q   <= bus.dataAdr;
        wdata_q <= bus.writeData;
        be_q    <= bus.byteEn;
        wr_q    <= bus.memWrite;
      end
      if (resp) begin
        if (!wr_q) rd_hold_q <= live_rd;
        if (wr_q && q_tohost && !simDone) begin
          simDone <= 1'b1;
          simPass <= (wdata_q == PASS_VALUE);
        end
        if (!q_tohost && !in_range(adr_q, DEPTH)) adrErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic compared against an associative-array memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  dmem_responder_if bus2();
  dmem_responder_if bus0();
  logic   done2, pass2, err2, done0, pass0, err0;
  state_t st2, st0;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .TOHOST_ADR(32'h54), .PASS_VALUE(32'd7)) dut (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .simDone(done2), .simPass(pass2), .adrErr(err2), .dbg_state(st2)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .TOHOST_ADR(32'h54), .PASS_VALUE(32'd7)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .simDone(done0), .simPass(pass0), .adrErr(err0), .dbg_state(st0)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory as word-indexed associative array, plus status.
  logic [31:0] ref_mem [int];
  logic        ref_done, ref_pass, ref_err;
  logic [31:0] ref_rd;

  task automatic model_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] w;
    if ((adr >> 2) == 32'd21) begin
      if (!ref_done) begin
        ref_done = 1'b1;
        ref_pass = (data == 32'd7);
      end
    end else if (adr < 32'd1024) begin
      w = ref_mem.exists(int'(adr >> 2)) ? ref_mem[int'(adr >> 2)] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
      ref_mem[int'(adr >> 2)] = w;
    end else begin
      ref_err = 1'b1;
    end
  endtask

  task automatic model_read(input logic [31:0] adr);
    if ((adr >> 2) == 32'd21)  ref_rd = {30'b0, ref_pass, ref_done};
    else if (adr < 32'd1024)   ref_rd = ref_mem[int'(adr >> 2)];
    else begin
      ref_rd  = 32'h0;
      ref_err = 1'b1;
    end
  endtask

  task automatic drive(input int which, input bit rd, input bit wr, input logic [31:0] adr,
                       input logic [31:0] data, input logic [3:0] be);
    if (which == 0) begin
      bus0.memRead = rd; bus0.memWrite = wr; bus0.dataAdr = adr;
      bus0.writeData = data; bus0.byteEn = be;
    end else begin
      bus2.memRead = rd; bus2.memWrite = wr; bus2.dataAdr = adr;
      bus2.writeData = data; bus2.byteEn = be;
    end
  endtask

  // Issue one request, count cycles to memReady, then drop the request.
  task automatic bus_op(input int which, input bit rd, input bit wr, input logic [31:0] adr,
                        input logic [31:0] data, input logic [3:0] be,
                        output logic [31:0] rdata, output int lat);
    logic rdy;
    @(negedge clk);
    drive(which, rd, wr, adr, data, be);
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      rdy = (which == 0) ? bus0.memReady : bus2.memReady;
    end
    rdata = (which == 0) ? bus0.readData : bus2.readData;
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("ready_width", {31'b0, (which == 0) ? bus0.memReady : bus2.memReady}, 32'h0);
  endtask

  task automatic txn(input string tag, input bit rd, input bit wr, input logic [31:0] adr,
                     input logic [31:0] data, input logic [3:0] be);
    logic [31:0] got;
    int lat;
    bus_op(2, rd, wr, adr, data, be, got, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    if (wr) model_write(adr, data, be);
    else    model_read(adr);
    check({tag, "_rdata"}, got, ref_rd);
    check({tag, "_hold"}, bus2.readData, ref_rd);
    check({tag, "_status"}, {29'b0, err2, pass2, done2}, {29'b0, ref_err, ref_pass, ref_done});
  endtask

  task automatic do_reset();
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ref_done = 1'b0; ref_pass = 1'b0; ref_err = 1'b0; ref_rd = 32'h0;
  endtask

  initial begin
    logic [31:0] got, adr;
    int lat, kind;
    bit saw;
    rst = 1'b0;
    do_reset();
    #1;
    check("rst_state", {30'b0, st2}, {30'b0, IDLE});
    check("rst_state0", {30'b0, st0}, {30'b0, IDLE});
    check("rst_outputs", {28'b0, bus2.memReady, done2, pass2, err2}, 32'h0);
    check("rst_rdata", bus2.readData, 32'h0);

    txn("wr_full", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn("rd_full", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    txn("wr_lane1", 1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    txn("rd_lane1", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("lane_merge", ref_rd, 32'hDEADAAEF);
    txn("wr_be0", 1'b0, 1'b1, 32'h10, 32'h12345678, 4'h0);
    txn("rd_be0", 1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
    txn("wr_20", 1'b0, 1'b1, 32'h20, 32'h13572468, 4'hF);
    txn("host_pass", 1'b0, 1'b1, 32'h54, 32'd7, 4'hF);
    check("host_pass_flags", {30'b0, pass2, done2}, 32'h3);
    txn("host_again", 1'b0, 1'b1, 32'h54, 32'd5, 4'hF);
    txn("host_rd", 1'b1, 1'b0, 32'h54, 32'h0, 4'h0);

    // Prefill words 0..15 (skipping 0x10/0x20 already known) then random traffic.
    for (int w = 0; w < 16; w++)
      if (w != 4 && w != 8) txn("prefill", 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0:       adr = 32'h54 | 32'($urandom_range(0, 3));
        1:       adr = 32'h400 + 32'($urandom_range(0, 255) * 4);
        2:       adr = $urandom | 32'h8000_0000;
        default: adr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      endcase
      if (kind < 5)      txn("rnd_rd", 1'b1, 1'b0, adr, 32'h0, 4'h0);
      else if (kind < 9) txn("rnd_wr", 1'b0, 1'b1, adr, $urandom, 4'($urandom_range(0, 15)));
      else               txn("rnd_rdwr", 1'b1, 1'b1, adr, $urandom, 4'($urandom_range(0, 15)));
    end

    do_reset();
    #1;
    check("rst2_flags", {29'b0, err2, pass2, done2}, 32'h0);
    txn("host_fail", 1'b0, 1'b1, 32'h54, 32'd3, 4'hF);
    check("host_fail_flags", {30'b0, pass2, done2}, 32'h1);
    txn("oor_rd", 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    check("oor_err", {31'b0, err2}, 32'h1);

    // Reset while a write to 0x20 sits in WAIT: no handshake, no commit.
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    check("wait_state", {30'b0, st2}, {30'b0, WAIT});
    rst = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus2.memReady) saw = 1'b1;
    end
    rst = 1'b1;
    ref_done = 1'b0; ref_pass = 1'b0; ref_err = 1'b0; ref_rd = 32'h0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus2.memReady) saw = 1'b1;
    end
    check("rst_drop_ready", {31'b0, saw}, 32'h0);
    txn("rd_20_old", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

    // Zero-wait-state instance.
    bus_op(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, got, lat);
    check("w0_wr_lat", 32'(lat), 32'd1);
    bus_op(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, got, lat);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rdata", got, 32'hCAFEF00D);
    check("w0_flags", {29'b0, err0, pass0, done0}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
